// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared defaults and FSM encoding for the run-time clock divider.
package clk_div_pkg;
  localparam int DIV_W   = 4;
  localparam int DEF_DIV = 7;
  localparam int MIN_DIV = 2;
  typedef enum logic {ST_IDLE = 1'b0, ST_PEND = 1'b1} state_e;
endpackage

// File: rtl/clk_div_core.sv
// clk_div_core: 50%-duty integer divider; posedge counter plus negedge half-cycle flop for odd ratios.
module clk_div_core #(
  parameter int DIV_W   = clk_div_pkg::DIV_W,
  parameter int DEF_DIV = clk_div_pkg::DEF_DIV
) (
  input  logic             clk,
  input  logic             res,
  input  logic [DIV_W-1:0] div,
  input  logic             run,
  output logic             div_clk,
  output logic             last
);
  import clk_div_pkg::*;
  logic [DIV_W-1:0] cnt_q, cnt_d, n_m1;
  logic run_q, pos_q, pos_d, neg_q;
  // A restart after a stop always begins a fresh period, even if cnt is parked at a stale N-1.
  always_comb begin
    n_m1 = div - DIV_W'(1);
    last = cnt_q == n_m1;
    cnt_d = !run ? n_m1 : (last || !run_q) ? '0 : cnt_q + DIV_W'(1);
    pos_d = run && (cnt_d < (div >> 1));
    div_clk = div[0] ? (pos_q | neg_q) : pos_q;
  end
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      cnt_q <= DIV_W'(DEF_DIV - 1);
      run_q <= 1'b0;
      pos_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run;
      pos_q <= pos_d;
    end
  end
  always_ff @(negedge clk or negedge res) begin
    if (!res) neg_q <= 1'b0;
    else neg_q <= pos_q;
  end
endmodule

// File: rtl/clk_div_sched.sv
// clk_div_sched: owns divide ratio and run/stop state; ratio and run changes land only on period boundaries.
module clk_div_sched #(
  parameter int DIV_W   = clk_div_pkg::DIV_W,
  parameter int DEF_DIV = clk_div_pkg::DEF_DIV,
  parameter int MIN_DIV = clk_div_pkg::MIN_DIV
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic [DIV_W-1:0] cur_div,
  output logic             busy,
  output logic             running,
  output logic             period_tick,
  output logic             div_clk
);
  import clk_div_pkg::*;
  state_e state_q, state_d;
  logic [DIV_W-1:0] cur_q, cur_d, pend_q, pend_d;
  logic run_q, run_d, err_q, err_d, last, bnd, xfer, legal, apply;
  always_comb begin
    bnd = last | ~run_q;
    xfer = cfg_valid && state_q == ST_IDLE;
    legal = cfg_div >= DIV_W'(MIN_DIV);
    apply = state_q == ST_PEND && bnd;
    run_d = bnd ? en : run_q;
    cur_d = apply ? pend_q : cur_q;
    pend_d = (xfer && legal) ? cfg_div : pend_q;
    err_d = xfer && !legal;
    state_d = apply ? ST_IDLE : (xfer && legal) ? ST_PEND : state_q;
  end
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= ST_IDLE;
      cur_q <= DIV_W'(DEF_DIV);
      pend_q <= DIV_W'(DEF_DIV);
      run_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q <= cur_d;
      pend_q <= pend_d;
      run_q <= run_d;
      err_q <= err_d;
    end
  end
  assign cfg_ready = state_q == ST_IDLE;
  assign busy = state_q == ST_PEND;
  assign cur_div = cur_q;
  assign running = run_q;
  assign cfg_err = err_q;
  assign period_tick = run_q & last;
  // The core sees next-cycle run so a stop parks the counter without starting a runt period.
  clk_div_core #(.DIV_W(DIV_W), .DEF_DIV(DEF_DIV)) u_core (
    .clk(clk), .res(res), .div(cur_q), .run(run_d), .div_clk(div_clk), .last(last)
  );
endmodule

// File: tb/tb_clk_div_sched.sv
// tb_clk_div_sched: scenario tasks and random traffic checked against a period-position reference model.
module tb_clk_div_sched;
  import clk_div_pkg::*;
  logic clk = 1'b0;
  logic res, en, cfg_valid, cfg_ready, cfg_err, busy, running, period_tick, div_clk;
  logic [3:0] cfg_div, cur_div;
  int checks = 0, errors = 0;
  int m_n, m_pn, m_pos;
  bit m_run, m_pend, m_err;

  clk_div_sched dut (
    .clk(clk), .res(res), .en(en), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err), .cur_div(cur_div), .busy(busy),
    .running(running), .period_tick(period_tick), .div_clk(div_clk)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] obs();
    return {cfg_ready, busy, running, period_tick, cfg_err, cur_div, div_clk};
  endfunction

  // div_clk is high for the first N half-clocks of each period.
  function automatic logic [9:0] mdl();
    return {!m_pend, m_pend, m_run, (m_run && m_pos == m_n - 1), m_err, 4'(m_n), (m_run && 2 * m_pos < m_n)};
  endfunction

  function automatic logic mdl_neg();
    return m_run && (2 * m_pos + 1 < m_n);
  endfunction

  task automatic mdl_reset();
    m_n = DEF_DIV; m_pn = 0; m_pos = 0; m_run = 0; m_pend = 0; m_err = 0;
  endtask

  task automatic cyc();
    bit bnd;
    @(posedge clk);
    bnd = !m_run || m_pos == m_n - 1;
    m_err = !m_pend && cfg_valid && cfg_div < MIN_DIV;
    if (m_pend && bnd) begin
      m_pend = 0;
      m_n = m_pn;
    end else if (!m_pend && cfg_valid && cfg_div >= MIN_DIV) begin
      m_pend = 1;
      m_pn = int'(cfg_div);
    end
    if (bnd) begin
      m_run = en;
      m_pos = 0;
    end else m_pos++;
    #1;
  endtask

  task automatic half();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    res = 0; en = 0; cfg_valid = 0; cfg_div = 0;
    mdl_reset();
    #12;
    checks++;
    if (obs() !== 10'b1_0_0_0_0_0111_0) begin errors++; $display("FAIL reset_hold: got %b exp %b", obs(), 10'b1_0_0_0_0_0111_0); end
    @(negedge clk);
    res = 1;
    #1;
    checks++;
    if (obs() !== mdl()) begin errors++; $display("FAIL reset_release: got %b exp %b", obs(), mdl()); end
  endtask

  task automatic test_run_default();
    int hi = 0, tk = 0;
    en = 1;
    for (int i = 0; i < 28; i++) begin
      cyc();
      checks++;
      if (obs() !== mdl()) begin errors++; $display("FAIL run_default c%0d: got %b exp %b", i, obs(), mdl()); end
      hi += int'(div_clk); tk += int'(period_tick);
      half();
      checks++;
      if (div_clk !== mdl_neg()) begin errors++; $display("FAIL run_default_neg c%0d: got %b exp %b", i, div_clk, mdl_neg()); end
      hi += int'(div_clk);
    end
    checks++;
    if (hi !== 28 || tk !== 4) begin errors++; $display("FAIL run_default_duty: got hi=%0d tk=%0d exp hi=28 tk=4", hi, tk); end
  endtask

  task automatic test_ratio_change();
    int w = 0, hc = -100;
    while (!(m_run && m_pos == 2) && w < 20) begin cyc(); half(); w++; end
    checks++;
    if (w >= 20) begin errors++; $display("FAIL ratio_wait: got timeout exp cnt=2"); end
    cfg_valid = 1; cfg_div = 4;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      checks++;
      if (obs() !== mdl()) begin errors++; $display("FAIL ratio c%0d: got %b exp %b", i, obs(), mdl()); end
      if (i <= 6) begin
        checks++;
        if (busy !== (i < 5)) begin errors++; $display("FAIL ratio_busy c%0d: got %b exp %b", i, busy, i < 5); end
      end
      for (int h = 0; h < 2; h++) begin
        if (h == 1) begin
          half();
          cfg_valid = 0;
          checks++;
          if (div_clk !== mdl_neg()) begin errors++; $display("FAIL ratio_neg c%0d: got %b exp %b", i, div_clk, mdl_neg()); end
        end
        if (div_clk) hc++;
        else begin
          if (hc > 0) begin
            checks++;
            if (hc < 4) begin errors++; $display("FAIL ratio_runt: got %0d halves exp >=4", hc); end
          end
          hc = 0;
        end
      end
    end
  endtask

  task automatic test_illegal();
    cfg_valid = 1; cfg_div = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (obs() !== mdl()) begin errors++; $display("FAIL illegal c%0d: got %b exp %b", i, obs(), mdl()); end
      checks++;
      if (cfg_err !== (i < 2) || cfg_ready !== 1'b1 || cur_div !== 4'd4)
        begin errors++; $display("FAIL illegal_err c%0d: got err=%b rdy=%b div=%0d exp err=%b rdy=1 div=4", i, cfg_err, cfg_ready, cur_div, i < 2); end
      half();
      cfg_div = 0;
      cfg_valid = (i == 0);
    end
  endtask

  task automatic test_stop();
    int w = 0;
    while (!(m_run && m_pos == 1) && w < 20) begin cyc(); half(); w++; end
    checks++;
    if (w >= 20) begin errors++; $display("FAIL stop_wait: got timeout exp cnt=1"); end
    en = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      checks++;
      if (obs() !== mdl()) begin errors++; $display("FAIL stop c%0d: got %b exp %b", i, obs(), mdl()); end
      half();
      checks++;
      if (div_clk !== mdl_neg()) begin errors++; $display("FAIL stop_neg c%0d: got %b exp %b", i, div_clk, mdl_neg()); end
    end
    checks++;
    if (running !== 1'b0 || div_clk !== 1'b0) begin errors++; $display("FAIL stop_idle: got run=%b clk=%b exp 0 0", running, div_clk); end
    cfg_valid = 1; cfg_div = 5;
    cyc();
    checks++;
    if (busy !== 1'b1 || cur_div !== 4'd4) begin errors++; $display("FAIL stop_pend: got busy=%b div=%0d exp busy=1 div=4", busy, cur_div); end
    half();
    cfg_valid = 0;
    cyc();
    checks++;
    if (busy !== 1'b0 || cur_div !== 4'd5) begin errors++; $display("FAIL stop_apply: got busy=%b div=%0d exp busy=0 div=5", busy, cur_div); end
    checks++;
    if (obs() !== mdl()) begin errors++; $display("FAIL stop_apply_mdl: got %b exp %b", obs(), mdl()); end
    half();
  endtask

  task automatic test_tick_xfer();
    int w = 0;
    cfg_valid = 1; cfg_div = 7;
    cyc(); half();
    cfg_valid = 0;
    cyc(); half();
    en = 1;
    while (!(m_run && m_pos == m_n - 1) && w < 20) begin cyc(); half(); w++; end
    checks++;
    if (w >= 20 || period_tick !== 1'b1) begin errors++; $display("FAIL tick_wait: got w=%0d tick=%b exp tick=1", w, period_tick); end
    cfg_valid = 1; cfg_div = 3;
    for (int i = 1; i <= 16; i++) begin
      cyc();
      checks++;
      if (obs() !== mdl()) begin errors++; $display("FAIL tick_xfer c%0d: got %b exp %b", i, obs(), mdl()); end
      checks++;
      if (period_tick !== (i == 7 || (i > 7 && (i - 7) % 3 == 0)))
        begin errors++; $display("FAIL tick_xfer_tick c%0d: got %b exp %b", i, period_tick, i == 7 || (i > 7 && (i - 7) % 3 == 0)); end
      half();
      cfg_valid = 0;
      checks++;
      if (div_clk !== mdl_neg()) begin errors++; $display("FAIL tick_xfer_neg c%0d: got %b exp %b", i, div_clk, mdl_neg()); end
    end
  endtask

  task automatic test_async_reset();
    int w = 0;
    while (!(m_run && m_pos == 0 && !m_pend) && w < 20) begin cyc(); half(); w++; end
    cfg_valid = 1; cfg_div = 9;
    cyc();
    checks++;
    if (w >= 20 || busy !== 1'b1 || div_clk !== 1'b1) begin errors++; $display("FAIL areset_setup: got w=%0d busy=%b clk=%b exp busy=1 clk=1", w, busy, div_clk); end
    cfg_valid = 0;
    #2 res = 0;
    mdl_reset();
    #1;
    checks++;
    if (div_clk !== 1'b0 || busy !== 1'b0 || cur_div !== 4'd7 || running !== 1'b0)
      begin errors++; $display("FAIL areset_async: got clk=%b busy=%b div=%0d run=%b exp 0 0 7 0", div_clk, busy, cur_div, running); end
    @(negedge clk);
    @(negedge clk);
    res = 1;
    #1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      checks++;
      if (obs() !== mdl()) begin errors++; $display("FAIL areset_after c%0d: got %b exp %b", i, obs(), mdl()); end
      half();
      checks++;
      if (div_clk !== mdl_neg()) begin errors++; $display("FAIL areset_neg c%0d: got %b exp %b", i, div_clk, mdl_neg()); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) en = ~en;
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_div = 4'($urandom_range(0, 15));
      cyc();
      checks++;
      if (obs() !== mdl()) begin errors++; $display("FAIL random c%0d: got %b exp %b", i, obs(), mdl()); end
      half();
      checks++;
      if (div_clk !== mdl_neg()) begin errors++; $display("FAIL random_neg c%0d: got %b exp %b", i, div_clk, mdl_neg()); end
    end
  endtask

  initial begin
    test_reset();
    test_run_default();
    test_ratio_change();
    test_illegal();
    test_stop();
    test_tick_xfer();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
